// File: rtl/touch_event_filter.sv
// Touch filter: 4-sample averaging, screen scaling, press/move/release events into a 1-entry output register.
// Event appears one cycle after the completing strobe; a busy register stalls press/release and drops or merges moves.
module touch_event_filter #(
  parameter int RELEASE_CYCLES = 50000,
  parameter int MOVE_THRESH    = 4
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iTOUCH,
  input  logic        iSAMPLE_STB,
  input  logic [11:0] iX_RAW,
  input  logic [11:0] iY_RAW,
  output logic        oEVT_VALID,
  input  logic        iEVT_READY,
  output logic [1:0]  oEVT_TYPE,
  output logic [9:0]  oX,
  output logic [8:0]  oY
);
  localparam int LW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [1:0] EV_PRESS = 2'b01, EV_MOVE = 2'b10, EV_REL = 2'b11;

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  state_t        state;
  logic [13:0]   sum_x, sum_y;
  logic [1:0]    win_cnt;
  logic [LW-1:0] low_cnt;
  logic          press_pend;
  logic [9:0]    last_x;
  logic [8:0]    last_y;

  logic          take, free, moved;
  logic [13:0]   sum_nx_x, sum_nx_y;
  logic [11:0]   avg_x, avg_y;
  logic [9:0]    scl_x;
  logic [8:0]    scl_y;
  logic [10:0]   dx, mag_x;
  logic [9:0]    dy, mag_y;

  // While a press is pending no sample is taken, so the scaler sees the stored completed sum.
  assign take     = iSAMPLE_STB & iTOUCH & ~press_pend & (state != REL);
  assign sum_nx_x = sum_x + (take ? {2'b00, iX_RAW} : 14'd0);
  assign sum_nx_y = sum_y + (take ? {2'b00, iY_RAW} : 14'd0);
  assign avg_x    = 12'(sum_nx_x >> 2);
  assign avg_y    = 12'(sum_nx_y >> 2);
  assign scl_x    = 10'((22'(avg_x) * 22'd800) >> 12);
  assign scl_y    = 9'((21'(avg_y) * 21'd480) >> 12);
  assign dx       = {1'b0, scl_x} - {1'b0, last_x};
  assign dy       = {1'b0, scl_y} - {1'b0, last_y};
  assign mag_x    = dx[10] ? (11'd0 - dx) : dx;
  assign mag_y    = dy[9] ? (10'd0 - dy) : dy;
  assign moved    = (mag_x >= 11'(MOVE_THRESH)) || (mag_y >= 10'(MOVE_THRESH));
  assign free     = ~oEVT_VALID | iEVT_READY;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= IDLE;
      sum_x      <= '0;
      sum_y      <= '0;
      win_cnt    <= '0;
      low_cnt    <= '0;
      press_pend <= 1'b0;
      last_x     <= '0;
      last_y     <= '0;
      oEVT_VALID <= 1'b0;
      oEVT_TYPE  <= 2'b00;
      oX         <= '0;
      oY         <= '0;
    end else begin
      if (oEVT_VALID && iEVT_READY) oEVT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state   <= ARM;
            sum_x   <= sum_nx_x;
            sum_y   <= sum_nx_y;
            win_cnt <= 2'd1;
          end
        end
        ARM: begin
          if (press_pend || (take && win_cnt == 2'd3)) begin
            if (free) begin
              oEVT_VALID <= 1'b1;
              oEVT_TYPE  <= EV_PRESS;
              oX         <= scl_x;
              oY         <= scl_y;
              last_x     <= scl_x;
              last_y     <= scl_y;
              press_pend <= 1'b0;
              state      <= HELD;
              sum_x      <= '0;
              sum_y      <= '0;
              win_cnt    <= '0;
              low_cnt    <= '0;
            end else begin
              press_pend <= 1'b1;
              sum_x      <= sum_nx_x;
              sum_y      <= sum_nx_y;
            end
          end else if (!iTOUCH) begin
            state   <= IDLE;
            sum_x   <= '0;
            sum_y   <= '0;
            win_cnt <= '0;
          end else if (take) begin
            sum_x   <= sum_nx_x;
            sum_y   <= sum_nx_y;
            win_cnt <= win_cnt + 2'd1;
          end
        end
        HELD: begin
          if (!iTOUCH) begin
            if (low_cnt == LW'(RELEASE_CYCLES - 1)) begin
              state   <= REL;
              low_cnt <= '0;
              sum_x   <= '0;
              sum_y   <= '0;
              win_cnt <= '0;
            end else begin
              low_cnt <= low_cnt + 1'b1;
            end
          end else begin
            low_cnt <= '0;
            if (take && win_cnt == 2'd3) begin
              sum_x   <= '0;
              sum_y   <= '0;
              win_cnt <= '0;
              // An unaccepted move is merged; an unaccepted press wins and the move is lost.
              if (moved && (free || oEVT_TYPE == EV_MOVE)) begin
                oEVT_VALID <= 1'b1;
                oEVT_TYPE  <= EV_MOVE;
                oX         <= scl_x;
                oY         <= scl_y;
                last_x     <= scl_x;
                last_y     <= scl_y;
              end
            end else if (take) begin
              sum_x   <= sum_nx_x;
              sum_y   <= sum_nx_y;
              win_cnt <= win_cnt + 2'd1;
            end
          end
        end
        REL: begin
          if (free) begin
            oEVT_VALID <= 1'b1;
            oEVT_TYPE  <= EV_REL;
            oX         <= last_x;
            oY         <= last_y;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_touch_event_filter.sv
// Directed bench for touch_event_filter; release timeout shortened so the gesture tests stay short.
module tb_touch_event_filter;
  localparam int RC = 40;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iTOUCH = 1'b0;
  logic        iSAMPLE_STB = 1'b0;
  logic [11:0] iX_RAW = '0;
  logic [11:0] iY_RAW = '0;
  logic        iEVT_READY = 1'b1;
  logic        oEVT_VALID;
  logic [1:0]  oEVT_TYPE;
  logic [9:0]  oX;
  logic [8:0]  oY;

  int total = 0;
  int bad   = 0;
  int ev_n  = 0;
  int ev_t  = 0;
  int ev_x  = 0;
  int ev_y  = 0;

  touch_event_filter #(.RELEASE_CYCLES(RC), .MOVE_THRESH(4)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iTOUCH(iTOUCH), .iSAMPLE_STB(iSAMPLE_STB),
    .iX_RAW(iX_RAW), .iY_RAW(iY_RAW), .oEVT_VALID(oEVT_VALID), .iEVT_READY(iEVT_READY),
    .oEVT_TYPE(oEVT_TYPE), .oX(oX), .oY(oY)
  );

  always #5 iCLK = ~iCLK;

  // Record every accepted event (handshake values as seen by the clock edge).
  always @(posedge iCLK) begin
    if (oEVT_VALID && iEVT_READY) begin
      ev_n <= ev_n + 1;
      ev_t <= int'(oEVT_TYPE);
      ev_x <= int'(oX);
      ev_y <= int'(oY);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic strobe(input int x, input int y);
    @(negedge iCLK);
    iSAMPLE_STB = 1'b1;
    iX_RAW = 12'(x);
    iY_RAW = 12'(y);
    @(negedge iCLK);
    iSAMPLE_STB = 1'b0;
  endtask

  task automatic window(input int x, input int y);
    for (int i = 0; i < 4; i++) strobe(x, y);
  endtask

  task automatic expect_out(input string tag, input int t, input int x, input int y);
    chk({tag, "_vld"}, int'(oEVT_VALID), 1);
    chk({tag, "_type"}, int'(oEVT_TYPE), t);
    chk({tag, "_x"}, int'(oX), x);
    chk({tag, "_y"}, int'(oY), y);
  endtask

  task automatic do_release(input string tag, input int x, input int y);
    iTOUCH = 1'b0;
    cycles(RC + 1);
    expect_out(tag, 3, x, y);
    cycles(1);
    chk({tag, "_gone"}, int'(oEVT_VALID), 0);
  endtask

  int n0;

  initial begin
    cycles(3);
    chk("rst_vld", int'(oEVT_VALID), 0);
    chk("rst_type", int'(oEVT_TYPE), 0);
    chk("rst_x", int'(oX), 0);
    chk("rst_y", int'(oY), 0);
    iRST_n = 1'b1;
    cycles(2);

    // Mid-scale press, one cycle after the 4th strobe
    iTOUCH = 1'b1;
    for (int i = 0; i < 3; i++) strobe(2048, 2048);
    chk("p_mid_early", int'(oEVT_VALID), 0);
    strobe(2048, 2048);
    expect_out("p_mid", 1, 400, 240);
    cycles(2);
    chk("p_mid_cnt", ev_n, 1);
    chk("p_mid_gone", int'(oEVT_VALID), 0);

    // Move threshold: 403 is below, 404 meets it
    window(2064, 2048);
    cycles(2);
    chk("mv403_cnt", ev_n, 1);
    chk("mv403_vld", int'(oEVT_VALID), 0);
    window(2069, 2048);
    expect_out("mv404", 2, 404, 240);
    cycles(2);
    chk("mv404_cnt", ev_n, 2);

    // One low cycle short of the release timeout
    iTOUCH = 1'b0;
    cycles(RC - 1);
    iTOUCH = 1'b1;
    cycles(5);
    chk("norel_cnt", ev_n, 2);
    chk("norel_vld", int'(oEVT_VALID), 0);
    do_release("rel1", 404, 240);
    chk("rel1_cnt", ev_n, 3);
    chk("rel1_type", ev_t, 3);

    // Full-scale and zero presses
    iTOUCH = 1'b1;
    window(4095, 4095);
    expect_out("p_max", 1, 799, 479);
    do_release("rel_max", 799, 479);
    iTOUCH = 1'b1;
    window(0, 0);
    expect_out("p_zero", 1, 0, 0);
    do_release("rel_zero", 0, 0);

    // Touch lost after 2 samples in ARM: no event, fresh window afterwards
    n0 = ev_n;
    iTOUCH = 1'b1;
    strobe(100, 100);
    strobe(100, 100);
    iTOUCH = 1'b0;
    cycles(4);
    chk("abort_cnt", ev_n, n0);
    chk("abort_vld", int'(oEVT_VALID), 0);
    iTOUCH = 1'b1;
    strobe(2048, 2048);
    strobe(2048, 2048);
    chk("abort_restart_early", int'(oEVT_VALID), 0);
    strobe(2048, 2048);
    strobe(2048, 2048);
    expect_out("abort_press", 1, 400, 240);
    cycles(1);
    do_release("rel_ab", 400, 240);

    // Press held under backpressure; moves meanwhile are dropped
    iEVT_READY = 1'b0;
    iTOUCH = 1'b1;
    window(2048, 2048);
    window(3000, 2048);
    window(1000, 2048);
    expect_out("p_hold", 1, 400, 240);
    n0 = ev_n;
    iEVT_READY = 1'b1;
    cycles(1);
    chk("p_hold_cnt", ev_n, n0 + 1);
    chk("p_hold_acc_x", ev_x, 400);
    iEVT_READY = 1'b0;

    // Pending move overwritten by a newer move
    window(3000, 2048);
    expect_out("mv_a", 2, 585, 240);
    window(1000, 1000);
    expect_out("mv_b", 2, 195, 117);
    iEVT_READY = 1'b1;
    cycles(1);
    chk("mv_b_cnt", ev_n, n0 + 2);
    chk("mv_b_acc_x", ev_x, 195);
    chk("mv_b_acc_y", ev_y, 117);

    // Reset during HELD with a move pending
    iEVT_READY = 1'b0;
    window(2048, 2048);
    expect_out("mv_pre_rst", 2, 400, 240);
    n0 = ev_n;
    @(negedge iCLK);
    iRST_n = 1'b0;
    #1;
    chk("mrst_vld", int'(oEVT_VALID), 0);
    chk("mrst_type", int'(oEVT_TYPE), 0);
    chk("mrst_x", int'(oX), 0);
    chk("mrst_y", int'(oY), 0);
    iTOUCH = 1'b0;
    iEVT_READY = 1'b1;
    cycles(2);
    iRST_n = 1'b1;
    cycles(RC + 10);
    chk("mrst_norel_cnt", ev_n, n0);
    chk("mrst_norel_vld", int'(oEVT_VALID), 0);

    // First press after reset
    iTOUCH = 1'b1;
    window(4095, 0);
    expect_out("p_after_rst", 1, 799, 0);
    cycles(2);
    chk("p_after_rst_cnt", ev_n, n0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/touch_event_filter.md
TOUCH_EVENT_FILTER -- requirements
Module: touch_event_filter

Interface
REQ-001 SHALL have parameter RELEASE_CYCLES, default 50000, meaning consecutive low iTOUCH cycles that declare a release.
REQ-002 SHALL have parameter MOVE_THRESH, default 4, meaning minimum per-axis pixel delta that triggers a move event.
REQ-003 SHALL have port iCLK  input  1  single clock for all logic.
REQ-004 SHALL have port iRST_n  input  1  reset, asynchronous, active-low; the only reset.
REQ-005 SHALL have port iTOUCH  input  1  pen-down level from the touch controller, synchronous to iCLK.
REQ-006 SHALL have port iSAMPLE_STB  input  1  one-cycle pulse: iX_RAW/iY_RAW hold a new sample.
REQ-007 SHALL have port iX_RAW  input  12  raw ADC X, valid when iSAMPLE_STB=1.
REQ-008 SHALL have port iY_RAW  input  12  raw ADC Y, valid when iSAMPLE_STB=1.
REQ-009 SHALL have port oEVT_VALID  output  1  event present.
REQ-010 SHALL have port iEVT_READY  input  1  consumer accepts the event.
REQ-011 SHALL have port oEVT_TYPE  output  2  01 press, 10 move, 11 release; 00 never emitted.
REQ-012 SHALL have port oX  output  10  screen X, 0..799.
REQ-013 SHALL have port oY  output  9  screen Y, 0..479.

Function
REQ-014 SHALL run FSM states IDLE, ARM, HELD, REL.
REQ-015 SHALL use a 4-sample averaging window: 14-bit sums per axis, average = sum>>2, truncated.
REQ-016 SHALL scale averages combinationally: X = (avgX*800)>>12, Y = (avgY*480)>>12, truncated; results never exceed 799/479.
REQ-017 IDLE: on iSAMPLE_STB with iTOUCH=1, SHALL go to ARM, accumulate that sample and set window count to 1.
REQ-018 ARM: SHALL accumulate each strobed sample while iTOUCH=1. On the 4th sample it SHALL go to HELD and emit a press at the scaled average. That position becomes last-emitted.
REQ-019 ARM: if iTOUCH=0 on any cycle, SHALL go to IDLE, clear the accumulators and emit no event.
REQ-020 HELD: every 4 strobed samples SHALL form an average. A move SHALL be emitted only if |X-lastX|>=MOVE_THRESH or |Y-lastY|>=MOVE_THRESH. Last-emitted SHALL update only when the move enters the output register.
REQ-021 HELD: a low-cycle counter SHALL count consecutive iTOUCH=0 cycles and clear on any iTOUCH=1. At RELEASE_CYCLES it SHALL go to REL and discard the partial window.
REQ-022 REL: SHALL load a release event carrying the last-emitted coordinates as soon as the output register is free or is emptied that same cycle, then go to IDLE. Samples SHALL be ignored while in REL.
REQ-023 Output SHALL be a single-entry register. An event SHALL transfer when oEVT_VALID&iEVT_READY on a rising iCLK edge. oEVT_TYPE/oX/oY SHALL stay stable while valid and not accepted.
REQ-024 Load into a register being emptied in the same cycle SHALL succeed with no bubble.
REQ-025 A press SHALL load only into an empty register or one being emptied that cycle. If the register is occupied, ARM SHALL hold its completed average and stay pending, with no new sampling, until the load succeeds.
REQ-026 A new move while the register holds an unaccepted move SHALL overwrite its coordinates; oEVT_VALID stays high.
REQ-027 A new move while the register holds a press SHALL be dropped.
REQ-028 Press and release events SHALL never be dropped or overwritten.
REQ-029 iSAMPLE_STB with iTOUCH=0 SHALL be ignored in every state.

Reset
REQ-030 While iRST_n=0, the block SHALL hold: oEVT_VALID=0, oEVT_TYPE=00, oX=0, oY=0, FSM=IDLE, accumulators/window/low counters=0, last-emitted=(0,0).
REQ-031 Reset mid-gesture SHALL discard all state; no release event is produced after reset.
REQ-032 The first press SHALL be possible once 4 strobed samples arrive after iRST_n rises.

Verification
REQ-033 iTOUCH=1, iEVT_READY=1, four strobes raw (2048,2048) -> exactly one event: type 01, X=400, Y=240, one cycle after the 4th strobe.
REQ-034 Raw (4095,4095) x4 -> press at X=799, Y=479. Raw (0,0) x4 from a fresh touch -> press at X=0, Y=0.
REQ-035 Held at (400,240) with MOVE_THRESH=4: window giving X=403 -> no event; window giving X=404 -> move type 10, X=404, Y=240.
REQ-036 iTOUCH low for 49999 cycles then high -> no release. Low for 50000 cycles -> release type 11 with the last-emitted coordinates.
REQ-037 iEVT_READY=0 with press pending, then two move windows -> press stays presented unchanged and the moves are dropped. With a move pending, a second move overwrites it.
REQ-038 iTOUCH drops after 2 samples in ARM -> no event, FSM back in IDLE. iRST_n pulsed low during HELD -> outputs 0 immediately and no release event.
